hdmi_ctrl_axil_slave: RTL and testbench

AXI4-Lite slave register file: the responder end of the host control path that configures the HDMI interface. Accepts single-beat AXI4-Lite writes and reads from the PS/VIP master and drives the static configuration outputs consumed by the HDMI timing/pixel logic. Also exposes a read-only status/frame-counter register.

---
 rtl/hdmi_ctrl_axil_slave.sv | 200 ++++++++++++++++++++
 tb/tb_hdmi_ctrl_axil_slave.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_ctrl_axil_slave.sv
// AXI4-Lite register file for HDMI configuration: four RW config registers plus an RO frame counter.
// Define HDMI_CTRL_SHADOW_EN to drive cfg_* from frame-synchronous shadow copies.
module hdmi_ctrl_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic                              frame_start,
    output logic [31:0]                       cfg_ctrl,
    output logic [31:0]                       cfg_h,
    output logic [31:0]                       cfg_v,
    output logic [31:0]                       cfg_color
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [3:0][31:0] regs_q, regs_d;
    logic [31:0]      status_q, status_d;
    logic             aw_held_q, aw_held_d;
    logic [2:0]       aw_idx_q, aw_idx_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    logic             aw_hs, w_hs, ar_hs, wr_commit;
    logic [2:0]       wr_idx, rd_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;

    // Byte-offset bits and protection attributes carry no meaning for this register file.
    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = !s00_axi_areset && !aw_held_q && !bvalid_q;
    assign s00_axi_wready  = !s00_axi_areset && !w_held_q && !bvalid_q;
    assign s00_axi_arready = !s00_axi_areset && !rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    // A beat handshaking this cycle counts as held, so AW+W together commit on the very next edge.
    assign wr_idx    = aw_held_q ? aw_idx_q : s00_axi_awaddr[4:2];
    assign wr_data   = w_held_q ? w_data_q : s00_axi_wdata;
    assign wr_strb   = w_held_q ? w_strb_q : s00_axi_wstrb;
    assign wr_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign rd_idx    = s00_axi_araddr[4:2];

    always_comb begin
        regs_d    = regs_q;
        status_d  = status_q + {31'd0, frame_start};
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[4:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s00_axi_wdata;
            w_strb_d = s00_axi_wstrb;
        end
        if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (!wr_idx[2]) begin
                for (int k = 0; k < 4; k++) begin
                    if (wr_strb[k]) begin
                        regs_d[wr_idx[1:0]][8*k +: 8] = wr_data[8*k +: 8];
                    end
                end
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end

        if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
        // Read data comes from the current flops, so a coincident write or frame tick is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            if (!rd_idx[2]) begin
                rdata_d = regs_q[rd_idx[1:0]];
            end else if (rd_idx == 3'd4) begin
                rdata_d = status_q;
            end else begin
                rdata_d = 32'd0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            regs_q    <= '0;
            status_q  <= '0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            status_q  <= status_d;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

`ifdef HDMI_CTRL_SHADOW_EN
    // Shadows sample the pre-commit registers, so a write landing on the frame tick waits a frame.
    logic [3:0][31:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) begin
            shadow_d = regs_q;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign cfg_ctrl  = shadow_q[0];
    assign cfg_h     = shadow_q[1];
    assign cfg_v     = shadow_q[2];
    assign cfg_color = shadow_q[3];
`else
    assign cfg_ctrl  = regs_q[0];
    assign cfg_h     = regs_q[1];
    assign cfg_v     = regs_q[2];
    assign cfg_color = regs_q[3];
`endif

endmodule

// File: tb/tb_hdmi_ctrl_axil_slave.sv
// Self-checking bench for hdmi_ctrl_axil_slave: vector table, corner-case sequences, random traffic vs a model.
module tb_hdmi_ctrl_axil_slave;
    logic        clk = 1'b0;
    logic        areset;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready, frame_start;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, cfg_ctrl, cfg_h, cfg_v, cfg_color;

    always #5 clk = ~clk;

    hdmi_ctrl_axil_slave dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .frame_start(frame_start),
        .cfg_ctrl(cfg_ctrl), .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_color(cfg_color)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: register file as plain arrays
    logic [31:0] m_reg [4];
    logic [31:0] m_shadow [4];
    logic [31:0] m_status;

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_reg[i] = 0;
            m_shadow[i] = 0;
        end
        m_status = 0;
    endtask

    function automatic logic [1:0] m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 5'h10) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) m_reg[a / 4][8*k +: 8] = d[8*k +: 8];
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic logic [33:0] m_read(input logic [4:0] a);
        if (a < 5'h10) return {2'b00, m_reg[a / 4]};
        if (a < 5'h14) return {2'b00, m_status};
        return {2'b10, 32'd0};
    endfunction

    function automatic logic [31:0] exp_cfg(input int i);
`ifdef HDMI_CTRL_SHADOW_EN
        return m_shadow[i];
`else
        return m_reg[i];
`endif
    endfunction

    task automatic check_cfg();
        check("cfg_ctrl", cfg_ctrl, exp_cfg(0));
        check("cfg_h", cfg_h, exp_cfg(1));
        check("cfg_v", cfg_v, exp_cfg(2));
        check("cfg_color", cfg_color, exp_cfg(3));
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, awf, wf;
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(aw_done && w_done) && n < 50) begin
            awf = awvalid && awready;
            wf = wvalid && wready;
            @(posedge clk);
            @(negedge clk);
            if (awf) begin aw_done = 1; awvalid = 0; end
            if (wf) begin w_done = 1; wvalid = 0; end
            n++;
        end
        if (n >= 50) check("aw_w_timeout", 32'd0, 32'd1);
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("b_timeout", 32'd0, 32'd1);
        resp = bresp;
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("ar_timeout", 32'd0, 32'd1);
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("r_timeout", 32'd0, 32'd1);
        d = rdata; resp = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1;
        for (int i = 0; i < 4; i++) m_shadow[i] = m_reg[i];
        m_status = m_status + 1;
        @(negedge clk);
        frame_start = 0;
    endtask

    typedef struct {
        logic        is_rd;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [1:0]  resp;
        logic [31:0] d, old, nv;
        logic [33:0] mr;
        logic [4:0]  a;

        vecs[0]  = '{1'b0, 5'h00, 32'h1,        4'hF, 32'h0,        2'b00};
        vecs[1]  = '{1'b0, 5'h04, 32'h2,        4'hF, 32'h0,        2'b00};
        vecs[2]  = '{1'b0, 5'h08, 32'h3,        4'hF, 32'h0,        2'b00};
        vecs[3]  = '{1'b0, 5'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
        vecs[4]  = '{1'b1, 5'h00, 32'h0,        4'h0, 32'h1,        2'b00};
        vecs[5]  = '{1'b1, 5'h04, 32'h0,        4'h0, 32'h2,        2'b00};
        vecs[6]  = '{1'b1, 5'h08, 32'h0,        4'h0, 32'h3,        2'b00};
        vecs[7]  = '{1'b1, 5'h0C, 32'h0,        4'h0, 32'h4,        2'b00};
        vecs[8]  = '{1'b0, 5'h04, 32'h0,        4'hF, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 5'h04, 32'hFFFFFFFF, 4'h5, 32'h0,        2'b00};
        vecs[10] = '{1'b1, 5'h04, 32'h0,        4'h0, 32'h00FF00FF, 2'b00};
        vecs[11] = '{1'b0, 5'h04, 32'h12345678, 4'h0, 32'h0,        2'b00};
        vecs[12] = '{1'b1, 5'h04, 32'h0,        4'h0, 32'h00FF00FF, 2'b00};
        vecs[13] = '{1'b0, 5'h10, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10};
        vecs[14] = '{1'b1, 5'h10, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[15] = '{1'b1, 5'h18, 32'h0,        4'h0, 32'h0,        2'b10};

        areset = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        frame_start = 0; wdata = 0; wstrb = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check_cfg();
        areset = 0;
        @(negedge clk);
        check("idle_awready", {31'd0, awready}, 32'd1);
        check("idle_arready", {31'd0, arready}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_rd) begin
                axi_read(vecs[i].addr, d, resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
            end else begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                void'(m_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
                check($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
                check_cfg();
            end
        end

        // W three cycles ahead of AW, B held off for four cycles
        @(negedge clk);
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1;
        check("wfirst_wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        wvalid = 0;
        repeat (2) @(negedge clk);
        check("wfirst_wready_held", {31'd0, wready}, 32'd0);
        awaddr = 5'h0C; awvalid = 1;
        check("wfirst_awready", {31'd0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 0;
        void'(m_write(5'h0C, 32'hA5A5A5A5, 4'hF));
        for (int c = 0; c < 4; c++) begin
            check("bhold_bvalid", {31'd0, bvalid}, 32'd1);
            check("bhold_bresp", {30'd0, bresp}, 32'd0);
            check("bhold_awready", {31'd0, awready}, 32'd0);
            check("bhold_wready", {31'd0, wready}, 32'd0);
            @(negedge clk);
        end
        check_cfg();
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("bdone_bvalid", {31'd0, bvalid}, 32'd0);
        check("bdone_awready", {31'd0, awready}, 32'd1);
        axi_read(5'h0C, d, resp);
        check("wfirst_readback", d, 32'hA5A5A5A5);

        // Same-cycle read and write of REG0: minimum write latency, read sees old value
        old = m_reg[0];
        nv = 32'hC0DE0001;
        @(negedge clk);
        awaddr = 5'h00; wdata = nv; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 5'h00; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        void'(m_write(5'h00, nv, 4'hF));
        check("rw_bvalid", {31'd0, bvalid}, 32'd1);
        check("rw_rvalid", {31'd0, rvalid}, 32'd1);
        check("rw_rdata_old", rdata, old);
        check_cfg();
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        axi_read(5'h00, d, resp);
        check("rw_readback", d, nv);

        // Frame counter: three pulses, then a read coincident with a fourth
        repeat (3) pulse_frame();
        check_cfg();
        axi_read(5'h10, d, resp);
        check("status_3", d, 32'd3);
        @(negedge clk);
        araddr = 5'h10; arvalid = 1; frame_start = 1;
        for (int i = 0; i < 4; i++) m_shadow[i] = m_reg[i];
        @(negedge clk);
        arvalid = 0; frame_start = 0;
        m_status = m_status + 1;
        check("status_coinc", rdata, 32'd3);
        rready = 1;
        @(negedge clk);
        rready = 0;
        axi_read(5'h10, d, resp);
        check("status_4", d, 32'd4);

        // Reset while a read response is pending
        @(negedge clk);
        araddr = 5'h00; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        check("prerst_rvalid", {31'd0, rvalid}, 32'd1);
        areset = 1;
        check("inrst_arready", {31'd0, arready}, 32'd0);
        @(negedge clk);
        areset = 0;
        m_reset();
        check("postrst_rvalid", {31'd0, rvalid}, 32'd0);
        check_cfg();
        axi_read(5'h00, d, resp);
        check("postrst_reg0", d, 32'd0);

        // Random traffic against the model
        for (int it = 0; it < 80; it++) begin
            a = 5'($urandom_range(0, 7) * 4);
            case ($urandom_range(0, 3))
                0, 1: begin
                    nv = $urandom;
                    wstrb = 4'($urandom_range(0, 15));
                    d = {28'd0, wstrb};
                    axi_write(a, nv, d[3:0], resp);
                    check("rnd_bresp", {30'd0, resp}, {30'd0, m_write(a, nv, d[3:0])});
                    check_cfg();
                end
                2: begin
                    mr = m_read(a);
                    axi_read(a, d, resp);
                    check("rnd_rdata", d, mr[31:0]);
                    check("rnd_rresp", {30'd0, resp}, {30'd0, mr[33:32]});
                end
                default: begin
                    pulse_frame();
                    check_cfg();
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
